// File: rtl/operand_fetch.sv
// Operand-fetch stage between decode and execute.
//
// Accepts decoded instructions over a valid/ready handshake, drives the
// regfile read addresses combinationally, captures operands with a
// same-cycle writeback bypass, and presents them registered to execute.
// A per-register scoreboard tracks outstanding destination writes.
// Issue stalls on RAW hazards (a source is pending) and on WAW hazards
// (the destination is pending). A writeback arriving in the same cycle
// resolves either kind of hazard.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake
//   in_rs1/in_rs2/in_rd        source and destination register addresses
//   in_rd_we, in_op            destination write flag, pass-through opcode
//   ra1/ra2, rd1/rd2           regfile read port (combinational read)
//   wb_we/wb_wa/wb_wd          writeback port (same signals as regfile write)
//   out_valid/out_ready        downstream handshake
//   out_a/out_b                captured operands
//   out_rd/out_rd_we/out_op    pass-through destination and opcode
//   pend_cnt                   number of pending scoreboard bits
module operand_fetch #(
    parameter int DW   = 32,
    parameter int AW   = 6,
    parameter int NREG = 64,
    parameter int OPW  = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_rs1,
    input  logic [AW-1:0]  in_rs2,
    input  logic [AW-1:0]  in_rd,
    input  logic           in_rd_we,
    input  logic [OPW-1:0] in_op,
    output logic [AW-1:0]  ra1,
    output logic [AW-1:0]  ra2,
    input  logic [DW-1:0]  rd1,
    input  logic [DW-1:0]  rd2,
    input  logic           wb_we,
    input  logic [AW-1:0]  wb_wa,
    input  logic [DW-1:0]  wb_wd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [AW-1:0]  out_rd,
    output logic           out_rd_we,
    output logic [OPW-1:0] out_op,
    output logic [AW:0]    pend_cnt
);

    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] clr_mask, set_mask;
    logic [AW:0]     cnt_q, cnt_d;

    logic            valid_q;
    logic [DW-1:0]   a_q, b_q;
    logic [AW-1:0]   rd_q;
    logic            rd_we_q;
    logic [OPW-1:0]  op_q;

    logic fwd1, fwd2, fwd_rd;
    logic hazard, accept;

    assign ra1 = in_rs1;
    assign ra2 = in_rs2;

    assign fwd1   = wb_we && (wb_wa == in_rs1);
    assign fwd2   = wb_we && (wb_wa == in_rs2);
    assign fwd_rd = wb_we && (wb_wa == in_rd);

    // A writeback landing this cycle clears its pending bit at the edge, so
    // it no longer blocks a reader (bypassed) or a new writer of that register.
    assign hazard = (pend_q[in_rs1] && !fwd1)
                 || (pend_q[in_rs2] && !fwd2)
                 || (in_rd_we && pend_q[in_rd] && !fwd_rd);

    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Set is applied after clear so a new writer wins over a retiring one.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_we) clr_mask[wb_wa] = 1'b1;
        if (accept && in_rd_we) set_mask[in_rd] = 1'b1;
        pend_d = (pend_q & ~clr_mask) | set_mask;
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            op_q    <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= fwd1 ? wb_wd : rd1;
            b_q     <= fwd2 ? wb_wd : rd2;
            rd_q    <= in_rd;
            rd_we_q <= in_rd_we;
            op_q    <= in_op;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_rd    = rd_q;
    assign out_rd_we = rd_we_q;
    assign out_op    = op_q;
    assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rd;
        logic        rd_we;
        logic [5:0]  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_rd_we = 1'b0;
    logic [5:0]  in_op = '0;
    logic [5:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        wb_we = 1'b0;
    logic [5:0]  wb_wa = '0;
    logic [31:0] wb_wd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a, out_b;
    logic [5:0]  out_rd;
    logic        out_rd_we;
    logic [5:0]  out_op;
    logic [6:0]  pend_cnt;

    logic [31:0] rf [64];
    bit   [63:0] m_pend;
    bit          m_ov;
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .in_op(in_op),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_op(out_op),
        .pend_cnt(pend_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d,
                         input logic we, input logic [5:0] op);
        in_valid = 1'b1;
        in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_we = we; in_op = op;
    endtask

    task automatic wb(input logic we, input logic [5:0] wa, input logic [31:0] wd);
        wb_we = we; wb_wa = wa; wb_wd = wd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_we = 1'b0;
    endtask

    // One clock: check handshake and presented outputs before the edge,
    // advance the model at the edge, check registered state just after.
    task automatic step();
        bit f1, f2, frd, haz, exp_rdy, acc;
        exp_t e;
        #1;
        f1  = wb_we && (wb_wa == in_rs1);
        f2  = wb_we && (wb_wa == in_rs2);
        frd = wb_we && (wb_wa == in_rd);
        haz = (m_pend[in_rs1] && !f1) || (m_pend[in_rs2] && !f2)
           || (in_rd_we && m_pend[in_rd] && !frd);
        exp_rdy = (!m_ov || out_ready) && !haz;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("ra1", 64'(ra1), 64'(in_rs1));
        chk("ra2", 64'(ra2), 64'(in_rs2));
        acc = in_valid && exp_rdy;
        if (m_ov) begin
            if (q.size() == 0) begin
                chk("sb_empty", 64'(q.size()), 64'(1));
            end else begin
                chk("out_a", 64'(out_a), 64'(q[0].a));
                chk("out_b", 64'(out_b), 64'(q[0].b));
                chk("out_rd", 64'(out_rd), 64'(q[0].rd));
                chk("out_rd_we", 64'(out_rd_we), 64'(q[0].rd_we));
                chk("out_op", 64'(out_op), 64'(q[0].op));
                if (out_ready) void'(q.pop_front());
            end
        end
        if (acc) begin
            e.a = f1 ? wb_wd : rf[in_rs1];
            e.b = f2 ? wb_wd : rf[in_rs2];
            e.rd = in_rd; e.rd_we = in_rd_we; e.op = in_op;
            q.push_back(e);
        end
        @(posedge clk);
        if (wb_we) begin
            rf[wb_wa] = wb_wd;
            m_pend[wb_wa] = 1'b0;
        end
        if (acc && in_rd_we) m_pend[in_rd] = 1'b1;
        if (acc) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("pend_cnt", 64'(pend_cnt), 64'($countones(m_pend)));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf[i] = 32'h1000 + 32'(i);
        rf[0] = 32'd11; rf[2] = 32'd10; rf[3] = 32'd25;
        m_pend = '0; m_ov = 1'b0;

        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_a", 64'(out_a), 64'(0));
        chk("rst_out_op", 64'(out_op), 64'(0));
        chk("rst_pend_cnt", 64'(pend_cnt), 64'(0));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // single instruction
        issue(2, 3, 5, 1, 4); step();
        chk("t1_a", 64'(out_a), 64'(10));
        chk("t1_b", 64'(out_b), 64'(25));
        chk("t1_rd", 64'(out_rd), 64'(5));
        chk("t1_cnt", 64'(pend_cnt), 64'(1));
        idle(); wb(1, 5, 32'd77); step();
        idle(); step();

        // same-cycle bypass
        issue(1, 0, 6, 0, 2); wb(1, 1, 32'd50); step();
        chk("byp_a", 64'(out_a), 64'(50));
        chk("byp_b", 64'(out_b), 64'(11));
        idle(); step();

        // RAW stall released by writeback
        issue(0, 0, 7, 1, 1); step();
        issue(7, 2, 10, 0, 3); #1;
        chk("raw_stall", 64'(in_ready), 64'(0));
        step();
        wb(1, 7, 32'd99); #1;
        chk("raw_release", 64'(in_ready), 64'(1));
        step();
        chk("raw_a", 64'(out_a), 64'(99));
        idle(); step();
        chk("raw_drain_cnt", 64'(pend_cnt), 64'(0));

        // WAW stall and set-wins
        issue(2, 3, 4, 1, 5); step();
        issue(2, 3, 4, 1, 6); #1;
        chk("waw_stall", 64'(in_ready), 64'(0));
        step();
        wb(1, 4, 32'd44); #1;
        chk("waw_release", 64'(in_ready), 64'(1));
        step();
        chk("waw_setwins", 64'(pend_cnt), 64'(1));
        idle(); wb(1, 4, 32'd45); step();
        idle(); step();

        // backpressure then back-to-back handoff
        out_ready = 1'b0;
        issue(2, 3, 11, 0, 7); step();
        issue(3, 2, 12, 0, 8);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 64'(in_ready), 64'(0));
            step();
            chk("bp_hold_op", 64'(out_op), 64'(7));
        end
        out_ready = 1'b1; #1;
        chk("bp_release", 64'(in_ready), 64'(1));
        step();
        chk("b2b_op", 64'(out_op), 64'(8));
        chk("b2b_a", 64'(out_a), 64'(25));
        idle(); step();

        // async reset mid-flight
        issue(0, 0, 8, 1, 1); step();
        issue(0, 0, 9, 1, 2); step();
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        chk("pre_rst_cnt", 64'(pend_cnt), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_cnt", 64'(pend_cnt), 64'(0));
        chk("arst_a", 64'(out_a), 64'(0));
        m_pend = '0; m_ov = 1'b0; q.delete();
        idle();
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // random mix on a small register window
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_rs1    = 6'($urandom_range(0, 7));
            in_rs2    = 6'($urandom_range(0, 7));
            in_rd     = 6'($urandom_range(0, 7));
            in_rd_we  = 1'($urandom_range(0, 1));
            in_op     = 6'($urandom_range(0, 63));
            wb_we     = 1'($urandom_range(0, 1));
            wb_wa     = 6'($urandom_range(0, 7));
            wb_wd     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // drain
        out_ready = 1'b1; in_valid = 1'b0;
        for (int r = 0; r < 8; r++) begin
            wb(1, 6'(r), 32'(r)); step();
        end
        idle(); step();
        chk("final_cnt", 64'(pend_cnt), 64'(0));
        chk("final_valid", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
